// File: rtl/pas_pkg.sv
// Shared constants and parameter checks for the pipelined adder/subtractor.
package pas_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic bit chunking_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit ripple adder; b arrives already inverted for subtraction.
module add_sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  always_comb begin
    sum   = '0;
    carry = '0;
    carry[0] = ci;
    for (int n = 0; n < CHUNK; n++) begin
      sum[n]     = a[n] ^ b[n] ^ carry[n];
      carry[n+1] = (a[n] & b[n]) | (carry[n] & (a[n] ^ b[n]));
    end
  end

  assign co    = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_subtractor.sv
// WIDTH-bit two's-complement adder/subtractor resolving CHUNK bits per stage,
// with a whole-pipeline enable driven by output backpressure.
module pipelined_adder_subtractor
  import pas_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             k,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!chunking_ok(WIDTH, CHUNK)) begin : g_chunk_check
    $error("pipelined_adder_subtractor: WIDTH must be a positive multiple of CHUNK");
  end

  logic             en;
  logic             sub_mode;
  logic [WIDTH-1:0] b_inv;

  logic [WIDTH-1:0] a_p     [STAGES];
  logic [WIDTH-1:0] b_p     [STAGES];
  logic [WIDTH-1:0] sum_p   [STAGES];
  logic             carry_p [STAGES];
  logic             vld_p   [STAGES];

  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign sub_mode  = (k == MODE_SUB);
  assign b_inv     = b ^ {WIDTH{sub_mode}};
  assign out_valid = vld_p[STAGES-1];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [CHUNK-1:0] ca, cb, ch_sum;
    logic             ci, ch_co, ch_msb, pvld;
    logic [WIDTH-1:0] psum, full_sum;

    if (i == 0) begin : g_first
      assign ca   = a[CHUNK-1:0];
      assign cb   = b_inv[CHUNK-1:0];
      assign ci   = cin ^ sub_mode;
      assign psum = '0;
      assign pvld = in_valid;
    end else begin : g_next
      assign ca   = a_p[i-1][i*CHUNK +: CHUNK];
      assign cb   = b_p[i-1][i*CHUNK +: CHUNK];
      assign ci   = carry_p[i-1];
      assign psum = sum_p[i-1];
      assign pvld = vld_p[i-1];
    end

    add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (ca),
      .b     (cb),
      .ci    (ci),
      .sum   (ch_sum),
      .co    (ch_co),
      .c_msb (ch_msb)
    );

    always_comb begin
      full_sum = psum;
      full_sum[i*CHUNK +: CHUNK] = ch_sum;
    end

    // ---- stage i register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p[i] <= 1'b0;
      end else if (en) begin
        vld_p[i] <= pvld;
      end
    end

    if (i < STAGES-1) begin : g_mid
      // Only the final stage needs the carry into the MSB.
      logic cm_unused;
      assign cm_unused = ch_msb;

      if (i == 0) begin : g_load
        always_ff @(posedge clk) begin
          if (en) begin
            a_p[i] <= a;
            b_p[i] <= b_inv;
          end
        end
      end else begin : g_pass
        always_ff @(posedge clk) begin
          if (en) begin
            a_p[i] <= a_p[i-1];
            b_p[i] <= b_p[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (en) begin
          sum_p[i]   <= full_sum;
          carry_p[i] <= ch_co;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s    <= '0;
          cout <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (en) begin
          s    <= full_sum;
          cout <= ch_co;
          ovf  <= ch_co ^ ch_msb;
          zero <= (full_sum == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Self-checking bench: directed boundary vectors, backpressure, mid-stream reset
// and a random stream, all scored against an arithmetic reference model.
module tb_pipelined_adder_subtractor;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             k = 1'b0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t mon_e;

  pipelined_adder_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .k         (k),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: signed overflow means the true sum leaves the signed range.
  function automatic res_t ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic kk, input logic ci);
    res_t        r;
    int unsigned yb, total;
    int          sx, sy, st, c_eff;
    yb    = kk ? (32'h0000_FFFF - 32'(y)) : 32'(y);
    c_eff = (ci != kk) ? 1 : 0;
    total = 32'(x) + yb + 32'(c_eff);
    r.s    = total[WIDTH-1:0];
    r.cout = (total >= 32'h0001_0000);
    sx = (x  >= 16'h8000) ? int'(x) - 65536 : int'(x);
    sy = (yb >= 32'h8000) ? int'(yb) - 65536 : int'(yb);
    st = sx + sy + c_eff;
    r.ovf  = (st > 32767) || (st < -32768);
    r.zero = (r.s == '0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("mon_spurious_result", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("mon_s",    32'(s),    32'(mon_e.s));
          chk_eq("mon_cout", 32'(cout), 32'(mon_e.cout));
          chk_eq("mon_ovf",  32'(ovf),  32'(mon_e.ovf));
          chk_eq("mon_zero", 32'(zero), 32'(mon_e.zero));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, k, cin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_one(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xk, input logic xc, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo, input logic ez);
    int n;
    a = xa; b = xb; k = xk; cin = xc;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk_eq({tag, "_latency"}, 32'(n), 32'(STAGES - 1));
    chk_eq({tag, "_s"},    32'(s),    32'(es));
    chk_eq({tag, "_cout"}, 32'(cout), 32'(ec));
    chk_eq({tag, "_ovf"},  32'(ovf),  32'(eo));
    chk_eq({tag, "_zero"}, 32'(zero), 32'(ez));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int j, c;
    logic stall, acc;

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      a = WIDTH'($urandom); b = WIDTH'($urandom); k = 1'($urandom); cin = 1'($urandom);
      tick();
      chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
      chk_eq("rst_s",         32'(s),         32'd0);
      chk_eq("rst_cout",      32'(cout),      32'd0);
      chk_eq("rst_ovf",       32'(ovf),       32'd0);
      chk_eq("rst_zero",      32'(zero),      32'd0);
      chk_eq("rst_in_ready",  32'(in_ready),  32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_eq("post_rst_idle", 32'(out_valid), 32'd0);
    end

    // Directed arithmetic vectors.
    send_one("add_basic",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    send_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    send_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send_one("sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send_one("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    send_one("sub_cin",    16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    send_one("sub_zero",   16'h0009, 16'h0009, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain("directed_drain");

    // Back-to-back stream with a 3-cycle stall.
    j = 0; c = 0;
    while (j < 16 && c < 100) begin
      stall = (c >= 6) && (c <= 8);
      out_ready = !stall;
      in_valid = 1'b1; a = WIDTH'(j); b = WIDTH'(j); k = j[0]; cin = 1'b0;
      #1;
      chk_eq("bp_in_ready", 32'(in_ready), 32'(!stall));
      if (stall) begin
        chk_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        if (exp_q.size() != 0) chk_eq("bp_hold_s", 32'(s), 32'(exp_q[0].s));
        else chk_eq("bp_hold_queue", 32'd0, 32'd1);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) j++;
      c++;
    end
    chk_eq("bp_all_accepted", 32'(j), 32'd16);
    drain("bp_drain");

    // Reset with a full pipeline.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); k = 1'($urandom); cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk_eq("midrst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("midrst_s",         32'(s),         32'd0);
    chk_eq("midrst_in_ready",  32'(in_ready),  32'd1);
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_eq("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    send_one("post_rst_add", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    drain("midrst_drain");

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = WIDTH'($urandom); b = WIDTH'($urandom); k = 1'($urandom); cin = 1'($urandom);
      tick();
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
